// File: rtl/pad_scanner.sv
// Saturn digital pad scanner for controller port 1: walks TH/TR through four selects,
// samples the data nibbles and publishes the SMPC JOY1 word. Optional macro: PAD_DEBOUNCE_EN.
module pad_scanner #(
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic        SCAN,
  input  logic [6:0]  P1I,
  output logic [6:0]  P1O,
  output logic [6:0]  P1DDR,
  output logic [15:0] JOY,
  output logic        CONNECTED,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    IDLE,
    PHASE,
    FINISH
  } state_t;

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYC);
  localparam logic [2:0] PAD_ID = 3'b100;

  state_t      state;
  logic [1:0]  phase;
  logic [1:0]  next_phase;
  logic [7:0]  cnt;
  logic        th;
  logic        tr;
  logic [3:0]  nib0;
  logic [3:0]  nib1;
  logic [3:0]  nib2;
  logic [3:0]  nib3;
  logic [15:0] word;
  logic        unused_pins;

`ifdef PAD_DEBOUNCE_EN
  logic [15:0] cand;
`endif

  assign next_phase  = phase + 2'd1;
  assign word        = {nib2, nib1, nib0, nib3[3], 3'b111};
  assign P1O         = {th, tr, 5'b0_0000};
  assign P1DDR       = 7'h60;
  assign unused_pins = ^P1I[6:4];

  // Phase index maps to select as TH = p[0], TR = p[1]: 00, 10, 01, 11.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      phase     <= '0;
      cnt       <= '0;
      th        <= 1'b1;
      tr        <= 1'b1;
      nib0      <= '1;
      nib1      <= '1;
      nib2      <= '1;
      nib3      <= '1;
      JOY       <= '1;
      CONNECTED <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
`ifdef PAD_DEBOUNCE_EN
      cand      <= '1;
`endif
    end else if (CE) begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (SCAN) begin
            state <= PHASE;
            phase <= '0;
            th    <= 1'b0;
            tr    <= 1'b0;
            cnt   <= SETTLE;
            BUSY  <= 1'b1;
          end
        end
        PHASE: begin
          if (cnt != '0) begin
            cnt <= cnt - 8'd1;
          end else begin
            unique case (phase)
              2'd0: nib0 <= P1I[3:0];
              2'd1: nib1 <= P1I[3:0];
              2'd2: nib2 <= P1I[3:0];
              2'd3: nib3 <= P1I[3:0];
              default: ;
            endcase
            if (phase != 2'd3) begin
              phase <= next_phase;
              th    <= next_phase[0];
              tr    <= next_phase[1];
              cnt   <= SETTLE;
            end else begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          if (nib3[2:0] == PAD_ID) begin
            CONNECTED <= 1'b1;
`ifdef PAD_DEBOUNCE_EN
            // Publish only a word seen on two consecutive valid scans.
            if (word == cand) JOY <= word;
            cand <= word;
`else
            JOY <= word;
`endif
          end else begin
            CONNECTED <= 1'b0;
            JOY       <= '1;
`ifdef PAD_DEBOUNCE_EN
            cand      <= '1;
`endif
          end
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          th    <= 1'b1;
          tr    <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_scanner.sv
// Randomized self-checking bench for pad_scanner: a pad model answers the select lines,
// and a scan-level reference model predicts JOY/CONNECTED and timing.
module tb_pad_scanner;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned LAT    = 4 * (SETTLE + 1) + 1;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        scan;
  logic [6:0]  p1i;
  logic [6:0]  p1o;
  logic [6:0]  p1ddr;
  logic [15:0] joy;
  logic        connected;
  logic        busy;
  logic        done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [3:0]  pad [4];
  logic [1:0]  sel_exp [4];

  logic [15:0] exp_joy;
  logic [15:0] cand;
  logic        exp_conn;

  pad_scanner #(.SETTLE_CYC(SETTLE)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CE       (ce),
    .SCAN     (scan),
    .P1I      (p1i),
    .P1O      (p1o),
    .P1DDR    (p1ddr),
    .JOY      (joy),
    .CONNECTED(connected),
    .BUSY     (busy),
    .DONE     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad answers the current TH/TR select with the matching nibble; TL idles high.
  always_comb begin
    case (p1o[6:5])
      2'b00:   p1i = {3'b001, pad[0]};
      2'b10:   p1i = {3'b001, pad[1]};
      2'b01:   p1i = {3'b001, pad[2]};
      default: p1i = {3'b001, pad[3]};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input logic ce_v, input logic scan_v, output logic ticked);
    @(negedge clk);
    ce   = ce_v;
    scan = scan_v;
    @(posedge clk);
    ticked = ce_v;
    #1;
  endtask

  task automatic model_reset();
    exp_joy  = 16'hFFFF;
    cand     = 16'hFFFF;
    exp_conn = 1'b0;
  endtask

  task automatic model_scan(input logic [3:0] n0, input logic [3:0] n1,
                            input logic [3:0] n2, input logic [3:0] n3);
    logic [15:0] w;
    w = {n2, n1, n0, n3[3], 3'b111};
    if (n3[2:0] == 3'b100) begin
      exp_conn = 1'b1;
`ifdef PAD_DEBOUNCE_EN
      if (w == cand) exp_joy = w;
      cand = w;
`else
      exp_joy = w;
`endif
    end else begin
      exp_conn = 1'b0;
      exp_joy  = 16'hFFFF;
      cand     = 16'hFFFF;
    end
  endtask

  task automatic do_scan(input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] n2,
                         input logic [3:0] n3, input bit rand_ce, input bit hold_scan,
                         input bit chk_sel);
    logic        t;
    logic        seen;
    logic        ce_v;
    logic        scan_v;
    int unsigned ticks;
    int unsigned cyc;
    pad[0] = n0; pad[1] = n1; pad[2] = n2; pad[3] = n3;
    tick(1'b1, 1'b1, t);
    check("busy_accept", busy, 1);
    ticks = 0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 400) begin
      ce_v   = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
      scan_v = hold_scan ? 1'b1 : ($urandom_range(0, 5) == 0);
      if (chk_sel && cyc < 12) check("select", p1o[6:5], sel_exp[cyc / 3]);
      check("busy_mid", busy, 1);
      check("joy_hold", joy, exp_joy);
      tick(ce_v, scan_v, t);
      cyc++;
      if (t) ticks++;
      if (done) seen = 1'b1;
    end
    model_scan(n0, n1, n2, n3);
    check("done_seen", seen, 1);
    check("done_latency", ticks, LAT);
    check("busy_finish", busy, 0);
    check("p1o_idle", p1o, 7'h60);
    check("joy", joy, exp_joy);
    check("connected", connected, exp_conn);
    if (rand_ce) begin
      tick(1'b0, 1'b0, t);
      check("done_frozen", done, 1);
    end
    tick(1'b1, 1'b0, t);
    check("done_clear", done, 0);
    check("busy_idle", busy, 0);
  endtask

  logic [3:0] r0, r1, r2, r3;
  logic       tk;

  initial begin
    sel_exp[0] = 2'b00; sel_exp[1] = 2'b10; sel_exp[2] = 2'b01; sel_exp[3] = 2'b11;
    pad[0] = 4'hF; pad[1] = 4'hF; pad[2] = 4'hF; pad[3] = 4'hC;
    rst_n = 1'b0; ce = 1'b0; scan = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_p1o", p1o, 7'h60);
    check("rst_p1ddr", p1ddr, 7'h60);
    check("rst_joy", joy, 16'hFFFF);
    check("rst_conn", connected, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_scan(4'hF, 4'hF, 4'hF, 4'hC, 1'b0, 1'b0, 1'b1);
    check("released_joy", joy, 16'hFFFF);
    check("released_conn", connected, 1);

    do_scan(4'hF, 4'hB, 4'hE, 4'hC, 1'b0, 1'b0, 1'b0);
    do_scan(4'hF, 4'hB, 4'hE, 4'hC, 1'b0, 1'b0, 1'b0);
    check("a_up_joy", joy, 16'hEBFF);

    do_scan(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    check("unplugged_joy", joy, 16'hFFFF);
    check("unplugged_conn", connected, 0);

    do_scan(4'h7, 4'hF, 4'hD, 4'h4, 1'b0, 1'b1, 1'b1);
    repeat (4) begin
      tick(1'b1, 1'b0, tk);
      check("held_no_rescan_busy", busy, 0);
      check("held_no_rescan_done", done, 0);
    end

    // Abandon a scan partway through phase 2.
    pad[0] = 4'h0; pad[1] = 4'h0; pad[2] = 4'h0; pad[3] = 4'h4;
    tick(1'b1, 1'b1, tk);
    repeat (7) tick(1'b1, 1'b0, tk);
    check("mid_p2_select", p1o[6:5], 2'b01);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_p1o", p1o, 7'h60);
    check("abort_busy", busy, 0);
    check("abort_joy", joy, exp_joy);
    check("abort_conn", connected, exp_conn);
    @(negedge clk);
    rst_n = 1'b1;

    r0 = 4'hF; r1 = 4'hF; r2 = 4'hF; r3 = 4'hC;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom);
        if ($urandom_range(0, 3) != 0) r3 = {1'($urandom), 3'b100};
        else begin
          r3 = 4'($urandom);
          if (r3[2:0] == 3'b100) r3[0] = 1'b1;
        end
      end
      do_scan(r0, r1, r2, r3, 1'b1, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pad_scanner.md
# pad_scanner

Scans a Saturn digital control pad on controller port 1 by sequencing the TH/TR select lines, sampling the returned data nibbles and assembling the 16-bit active-low button word consumed by the SMPC on its `JOY1` input. It sits directly upstream of the SMPC. It owns the port-1 pin drive and direction, and runs one scan per `SCAN` request, typically issued once per frame.

## Interface
- `SETTLE_CYC`, default 16: CE ticks to wait after changing select lines before sampling (0–255).
- `CLK` in 1: system clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `CE` in 1: clock enable; all state advances only on CE ticks (`CLK` edge with `CE`=1).
- `SCAN` in 1: scan request, sampled on CE ticks.
- `P1I` in 7: port-1 pin inputs; [3:0] = D3..D0 data, [4] = TL (unused).
- `P1O` out 7: port-1 pin outputs; [6] = TH, [5] = TR, others 0.
- `P1DDR` out 7: pin direction, constant 7'h60 (TH/TR outputs).
- `JOY` out 16: button word, active low, SMPC JOY1 format.
- `CONNECTED` out 1: last completed scan saw a valid digital-pad ID.
- `BUSY` out 1: scan in progress.
- `DONE` out 1: one-CE-tick pulse when a scan completes.

## Operation
- **States:**
  - IDLE: select lines driven TH=1, TR=1.
  - PHASE: four phases, p = 0..3.
  - FINISH.
- **IDLE → PHASE:** on a CE tick with `SCAN`=1, go to PHASE p=0, drive the p=0 select, load the counter with `SETTLE_CYC`, and set `BUSY`=1.
- **Select per phase (TH,TR):** p0 = 0,0; p1 = 1,0; p2 = 0,1; p3 = 1,1.
- **PHASE behaviour:**
  - Each CE tick with counter ≠ 0 decrements the counter.
  - The CE tick with counter = 0 samples `P1I[3:0]` into the phase nibble.
  - On that same tick, p<3 advances to p+1, drives the new select and reloads the counter; p=3 goes to FINISH.
- **Assembly:**
  - p0 nibble = R,X,Y,Z → word[7:4].
  - p1 nibble = START,A,C,B → word[11:8].
  - p2 nibble = RIGHT,LEFT,DOWN,UP → word[15:12].
  - p3 nibble: D3 = L → word[3]; D2..D0 = ID.
  - word[2:0] = 3'b111.
- **FINISH (one CE tick):**
  - ID == 3'b100: `CONNECTED`←1 and `JOY` is updated with the word (subject to Configuration).
  - Any other ID: `CONNECTED`←0 and `JOY`←16'hFFFF.
  - In both cases: `DONE`=1 for this tick, `BUSY`←0, select returns to 1,1, state → IDLE.
- **SCAN while BUSY:** ignored, not queued. A `SCAN` seen in the FINISH tick is also ignored.
- **Reset values:** `P1O`=7'h60, `P1DDR`=7'h60, `JOY`=16'hFFFF, `CONNECTED`=0, `BUSY`=0, `DONE`=0, state IDLE, counter 0.
- **Reset mid-scan:** abandons the scan immediately (asynchronously). `JOY` is not updated from the partial scan.

## Timing
- Each phase lasts `SETTLE_CYC`+1 CE ticks, so the select is stable for at least `SETTLE_CYC` ticks before the sample.
- Latency: `DONE` asserts on the 4·(`SETTLE_CYC`+1)+1-th CE tick after the accepting tick.
  - Example: `SETTLE_CYC`=2 with CE always high gives `DONE` 13 clocks after acceptance.
- `JOY` and `CONNECTED` change only on the FINISH tick and hold between scans.
- `BUSY` is high from the tick after acceptance through the FINISH tick.
- `CE`=0 freezes all state. `DONE` stays high until the next CE tick.

## Configuration
- Macro: `PAD_DEBOUNCE_EN`.
- **Defined:**
  - A 16-bit candidate register holds the previous valid word.
  - `JOY` updates only when the current valid word equals the candidate; the candidate is then always replaced by the current word.
  - An invalid ID still forces `JOY`=16'hFFFF and clears the candidate to 16'hFFFF immediately.
- **Undefined:** `JOY` takes every valid word directly. No candidate register exists.

## Test plan
- Pad model with all buttons released (nibbles F,F,F and ID nibble 4'hC), `SCAN` pulse → `JOY`=16'hFFFF, `CONNECTED`=1, `DONE` pulse.
- Press A and UP (p1=4'hB, p2=4'hE), scan twice → `JOY`=16'hEBFF.
- Unplugged port (`P1I` all 1s, ID 3'b111) → `JOY`=16'hFFFF, `CONNECTED`=0.
- `SETTLE_CYC`=2, CE always high:
  - `DONE` asserts exactly 13 clocks after the accepting tick.
  - Select sequence on `P1O`[6:5] is 00, 10, 01, 11 (bit order [6:5] = TH,TR), each held 3 clocks.
- `SCAN` held high throughout a scan → exactly one scan. Assert `RST_N` low during p2 → `P1O`=7'h60, `BUSY`=0, `JOY` unchanged at 16'hFFFF.
- With `PAD_DEBOUNCE_EN`: previous word 16'hFFFF, then one scan returning 16'hEBFF → `JOY` remains 16'hFFFF; a second 16'hEBFF scan → `JOY`=16'hEBFF.
